// File: rtl/simple_op_sequencer_if.sv
// Instruction, ALU-result and I/O handshake bundle between the sequencer and its surroundings.
// The slave side is the sequencer; the master side drives instructions and ALU/I/O results.
interface simple_op_sequencer_if;
    logic [15:0] instr;
    logic        instrValid;
    logic        ready;
    logic [3:0]  opselect;
    logic [3:0]  d;
    logic [2:0]  rsAddr;
    logic [2:0]  rdAddr;
    logic        isValid;
    logic        HaltFlag;
    logic        SZCVWriteFlag;
    logic        iRdWriteFlag;
    logic        S;
    logic        Z;
    logic        C;
    logic        V;
    logic [3:0]  szcv;
    logic        ioReq;
    logic        ioAck;
    logic        rdWrite;
    logic        nonAlu;
    logic        illegalOp;
    logic        halted;

    modport master (
        output instr, instrValid, HaltFlag, SZCVWriteFlag, iRdWriteFlag, S, Z, C, V, ioAck,
        input  ready, opselect, d, rsAddr, rdAddr, isValid, szcv, ioReq, rdWrite,
               nonAlu, illegalOp, halted
    );

    modport slave (
        input  instr, instrValid, HaltFlag, SZCVWriteFlag, iRdWriteFlag, S, Z, C, V, ioAck,
        output ready, opselect, d, rsAddr, rdAddr, isValid, szcv, ioReq, rdWrite,
               nonAlu, illegalOp, halted
    );
endinterface

// File: rtl/simple_op_sequencer.sv
// Single-instruction sequencer: latches an instruction, qualifies the ALU, waits on I/O,
// then commits flags and the register write.  HALT is left only through reset.
//
//   state  | meaning
//   IDLE   | ready, waiting for instrValid
//   DECODE | classify latched instruction (non-ALU / illegal / execute)
//   EXEC   | ALU qualified; branch to HALT, IOWAIT or WB
//   IOWAIT | ALU qualified, ioReq raised until ioAck
//   WB     | one-cycle register write-back
//   HALT   | absorbing halt
module simple_op_sequencer (
    input logic           clock,
    input logic           reset_n,
    simple_op_sequencer_if.slave bus
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] DECODE = 3'd1;
    localparam logic [2:0] EXEC   = 3'd2;
    localparam logic [2:0] IOWAIT = 3'd3;
    localparam logic [2:0] WB     = 3'd4;
    localparam logic [2:0] HALT   = 3'd5;

    logic [2:0]  state;
    logic [2:0]  state_nxt;
    logic [15:0] ir;
    logic [3:0]  szcv_q;
    logic        rd_wr_q;
    logic        is_alu;
    logic        is_illegal;
    logic        is_io;
    logic        last_valid;

    assign is_alu     = (ir[15:14] == 2'b11);
    assign is_illegal = (ir[7:4] == 4'b0111) || (ir[7:4] == 4'b1110);
    assign is_io      = (ir[7:4] == 4'b1100) || (ir[7:4] == 4'b1101);

    // Final qualified cycle: flags and the write request are captured here only.
    assign last_valid = ((state == EXEC) && !bus.HaltFlag && !is_io) ||
                        ((state == IOWAIT) && bus.ioAck);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.instrValid) state_nxt = DECODE;
            DECODE:  state_nxt = (!is_alu || is_illegal) ? IDLE : EXEC;
            EXEC: begin
                if (bus.HaltFlag)  state_nxt = HALT;
                else if (is_io)    state_nxt = IOWAIT;
                else               state_nxt = WB;
            end
            IOWAIT:  if (bus.ioAck) state_nxt = WB;
            WB:      state_nxt = IDLE;
            HALT:    state_nxt = HALT;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            ir      <= 16'h0000;
            szcv_q  <= 4'b0000;
            rd_wr_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if ((state == IDLE) && bus.instrValid)
                ir <= bus.instr;
            if (last_valid) begin
                rd_wr_q <= bus.iRdWriteFlag;
                if (bus.SZCVWriteFlag)
                    szcv_q <= {bus.S, bus.Z, bus.C, bus.V};
            end
        end
    end

    assign bus.ready     = (state == IDLE);
    assign bus.opselect  = ir[7:4];
    assign bus.d         = ir[3:0];
    assign bus.rsAddr    = ir[13:11];
    assign bus.rdAddr    = ir[10:8];
    assign bus.isValid   = (state == EXEC) || (state == IOWAIT);
    assign bus.ioReq     = (state == IOWAIT);
    assign bus.szcv      = szcv_q;
    assign bus.rdWrite   = (state == WB) && rd_wr_q;
    assign bus.nonAlu    = (state == DECODE) && !is_alu;
    assign bus.illegalOp = (state == DECODE) && is_alu && is_illegal;
    assign bus.halted    = (state == HALT);
endmodule

// File: tb/tb_simple_op_sequencer.sv
// Self-checking bench: directed vector table, hand-written halt/reset sequences and
// randomized instructions checked against a transaction-level reference model.
module tb_simple_op_sequencer;
    logic clock = 1'b0;
    logic reset_n = 1'b0;

    simple_op_sequencer_if bus();

    simple_op_sequencer dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [15:0] instr;
        logic        halt;
        logic        sw;
        logic        rw;
        logic [3:0]  flags;
        int          w;
    } op_t;

    // Cycle indices are counted from the accepting edge (1 = first cycle after it); 0 = never.
    typedef struct {
        int         ready_at;
        int         nonalu_at;
        int         illegal_at;
        int         isv_cnt;
        int         isv_first;
        int         ioreq_cnt;
        int         rd_cnt;
        int         rd_at;
        int         halted_at;
        logic [3:0] szcv;
    } res_t;

    typedef struct {
        op_t  op;
        res_t exp;
    } vec_t;

    int         checks = 0;
    int         errors = 0;
    logic [3:0] model_szcv = 4'b0000;
    vec_t       tbl[10];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic res_t model(input op_t op, input logic [3:0] prev);
        res_t e;
        int   iow;
        e = '{default: 0};
        e.szcv = prev;
        if (op.instr[15:14] != 2'b11) begin
            e.nonalu_at = 1;
            e.ready_at  = 2;
        end else if (op.instr[7:4] == 4'd7 || op.instr[7:4] == 4'd14) begin
            e.illegal_at = 1;
            e.ready_at   = 2;
        end else if (op.halt) begin
            e.isv_cnt   = 1;
            e.isv_first = 2;
            e.halted_at = 3;
        end else begin
            iow = (op.instr[7:4] == 4'd12 || op.instr[7:4] == 4'd13) ? op.w + 1 : 0;
            e.isv_cnt   = 1 + iow;
            e.isv_first = 2;
            e.ioreq_cnt = iow;
            e.ready_at  = 4 + iow;
            if (op.rw) begin
                e.rd_cnt = 1;
                e.rd_at  = 3 + iow;
            end
            if (op.sw) e.szcv = op.flags;
        end
        return e;
    endfunction

    task automatic set_alu(input op_t op);
        bus.HaltFlag      = op.halt;
        bus.SZCVWriteFlag = op.sw;
        bus.iRdWriteFlag  = op.rw;
        {bus.S, bus.Z, bus.C, bus.V} = op.flags;
    endtask

    task automatic run_op(input op_t op, output res_t r, output int stab_err);
        int io_seen;
        bit done;
        io_seen  = 0;
        done     = 1'b0;
        stab_err = 0;
        r = '{default: 0};
        @(negedge clock);
        chk("ready_before_issue", int'(bus.ready), 1);
        bus.instr      = op.instr;
        bus.instrValid = 1'b1;
        bus.ioAck      = 1'b0;
        set_alu(op);
        @(posedge clock);
        #1;
        bus.instrValid = 1'b0;
        bus.instr      = 16'($urandom);
        for (int cyc = 1; cyc <= 60 && !done; cyc++) begin
            @(negedge clock);
            if (bus.nonAlu)    r.nonalu_at  = cyc;
            if (bus.illegalOp) r.illegal_at = cyc;
            if (bus.isValid) begin
                r.isv_cnt++;
                if (r.isv_first == 0) r.isv_first = cyc;
            end
            if (bus.ioReq) r.ioreq_cnt++;
            if (bus.rdWrite) begin
                r.rd_cnt++;
                r.rd_at = cyc;
            end
            if (bus.halted && r.halted_at == 0) r.halted_at = cyc;
            if (!bus.ready && (bus.opselect != op.instr[7:4] || bus.d != op.instr[3:0] ||
                               bus.rsAddr != op.instr[13:11] || bus.rdAddr != op.instr[10:8]))
                stab_err++;
            if (bus.ready) begin
                r.ready_at = cyc;
                done = 1'b1;
            end else if (r.halted_at != 0 && cyc >= r.halted_at + 2) begin
                done = 1'b1;
            end
            // ALU results are scrambled on I/O wait cycles; only the acking cycle may count.
            if (bus.ioReq) begin
                if (io_seen >= op.w) begin
                    bus.ioAck = 1'b1;
                    set_alu(op);
                end else begin
                    bus.ioAck         = 1'b0;
                    bus.SZCVWriteFlag = 1'($urandom_range(0, 1));
                    bus.iRdWriteFlag  = 1'($urandom_range(0, 1));
                    {bus.S, bus.Z, bus.C, bus.V} = 4'($urandom_range(0, 15));
                end
                io_seen++;
            end else begin
                bus.ioAck = 1'($urandom_range(0, 1));
                set_alu(op);
            end
        end
        if (!done) chk("op_timeout", 0, 1);
        bus.ioAck = 1'b0;
        r.szcv = bus.szcv;
    endtask

    task automatic compare(input string tag, input res_t a, input res_t e, input int stab);
        chk({tag, ".ready_at"},   a.ready_at,   e.ready_at);
        chk({tag, ".nonalu_at"},  a.nonalu_at,  e.nonalu_at);
        chk({tag, ".illegal_at"}, a.illegal_at, e.illegal_at);
        chk({tag, ".isv_cnt"},    a.isv_cnt,    e.isv_cnt);
        chk({tag, ".isv_first"},  a.isv_first,  e.isv_first);
        chk({tag, ".ioreq_cnt"},  a.ioreq_cnt,  e.ioreq_cnt);
        chk({tag, ".rd_cnt"},     a.rd_cnt,     e.rd_cnt);
        chk({tag, ".rd_at"},      a.rd_at,      e.rd_at);
        chk({tag, ".halted_at"},  a.halted_at,  e.halted_at);
        chk({tag, ".szcv"},       int'(a.szcv), int'(e.szcv));
        chk({tag, ".fields_stable"}, stab, 0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        chk({tag, ".ready"},   int'(bus.ready), 1);
        chk({tag, ".halted"},  int'(bus.halted), 0);
        chk({tag, ".strobes"}, int'({bus.isValid, bus.ioReq, bus.rdWrite, bus.nonAlu, bus.illegalOp}), 0);
        chk({tag, ".szcv"},    int'(bus.szcv), 0);
        chk({tag, ".ir"},      int'({bus.rsAddr, bus.rdAddr, bus.opselect, bus.d}), 0);
        @(negedge clock);
        reset_n = 1'b1;
        model_szcv = 4'b0000;
    endtask

    initial begin
        op_t  op;
        res_t r;
        res_t e;
        int   stab;
        int   bad;
        int   seen;
        int   rdseen;

        bus.instr = 16'h0000;
        bus.instrValid = 1'b0;
        bus.HaltFlag = 1'b0;
        bus.SZCVWriteFlag = 1'b0;
        bus.iRdWriteFlag = 1'b0;
        {bus.S, bus.Z, bus.C, bus.V} = 4'b0000;
        bus.ioAck = 1'b0;

        //           instr     halt  sw    rw    flags   w     rdy nA il isv 1st io rd rdat hlt szcv
        tbl[0] = '{'{16'hC900, 1'b0, 1'b1, 1'b1, 4'b0110, 0}, '{4, 0, 0, 1, 2, 0, 1, 3, 0, 4'b0110}};
        tbl[1] = '{'{16'hC850, 1'b0, 1'b1, 1'b0, 4'b1001, 0}, '{4, 0, 0, 1, 2, 0, 0, 0, 0, 4'b1001}};
        tbl[2] = '{'{16'hD2D0, 1'b0, 1'b0, 1'b0, 4'b1111, 5}, '{10, 0, 0, 7, 2, 6, 0, 0, 0, 4'b1001}};
        tbl[3] = '{'{16'hC0C3, 1'b0, 1'b1, 1'b1, 4'b0011, 0}, '{5, 0, 0, 2, 2, 1, 1, 4, 0, 4'b0011}};
        tbl[4] = '{'{16'h4123, 1'b0, 1'b1, 1'b1, 4'b1111, 0}, '{2, 1, 0, 0, 0, 0, 0, 0, 0, 4'b0011}};
        tbl[5] = '{'{16'hC975, 1'b0, 1'b1, 1'b1, 4'b1111, 0}, '{2, 0, 1, 0, 0, 0, 0, 0, 0, 4'b0011}};
        tbl[6] = '{'{16'hFFE0, 1'b0, 1'b1, 1'b1, 4'b1010, 0}, '{2, 0, 1, 0, 0, 0, 0, 0, 0, 4'b0011}};
        tbl[7] = '{'{16'h00E0, 1'b0, 1'b1, 1'b1, 4'b1010, 0}, '{2, 1, 0, 0, 0, 0, 0, 0, 0, 4'b0011}};
        tbl[8] = '{'{16'hC912, 1'b0, 1'b0, 1'b1, 4'b1111, 0}, '{4, 0, 0, 1, 2, 0, 1, 3, 0, 4'b0011}};
        tbl[9] = '{'{16'hC5D7, 1'b0, 1'b1, 1'b1, 4'b1100, 2}, '{7, 0, 0, 4, 2, 3, 1, 6, 0, 4'b1100}};

        do_reset("rst_init");

        for (int i = 0; i < 10; i++) begin
            run_op(tbl[i].op, r, stab);
            compare($sformatf("vec%0d", i), r, tbl[i].exp, stab);
        end
        model_szcv = tbl[9].exp.szcv;

        // Halt is absorbing: later instructions are refused until reset.
        do_reset("rst_pre_hlt");
        op = '{16'hC0F0, 1'b1, 1'b1, 1'b1, 4'b1111, 0};
        run_op(op, r, stab);
        e = '{0, 0, 0, 1, 2, 0, 0, 0, 3, 4'b0000};
        compare("hlt", r, e, stab);
        bad = 0;
        @(negedge clock);
        bus.instr      = 16'hC900;
        bus.instrValid = 1'b1;
        bus.HaltFlag   = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            if (bus.ready || !bus.halted || bus.isValid || bus.ioReq || bus.rdWrite) bad++;
        end
        bus.instrValid = 1'b0;
        chk("hlt_absorb", bad, 0);
        do_reset("rst_after_hlt");

        // Reset while waiting on I/O must drop everything with no write-back.
        op = '{16'hC900, 1'b0, 1'b1, 1'b1, 4'b1011, 0};
        e = model(op, model_szcv);
        run_op(op, r, stab);
        compare("pre_io", r, e, stab);
        @(negedge clock);
        bus.instr      = 16'hC5D1;
        bus.instrValid = 1'b1;
        bus.HaltFlag   = 1'b0;
        bus.SZCVWriteFlag = 1'b1;
        bus.iRdWriteFlag  = 1'b1;
        {bus.S, bus.Z, bus.C, bus.V} = 4'b1111;
        bus.ioAck = 1'b0;
        @(posedge clock);
        #1;
        bus.instrValid = 1'b0;
        seen = 0;
        rdseen = 0;
        for (int k = 0; k < 10 && seen < 3; k++) begin
            @(negedge clock);
            if (bus.ioReq) seen++;
            if (bus.rdWrite) rdseen++;
        end
        chk("io_wait_reached", seen, 3);
        #2;
        reset_n = 1'b0;
        bus.ioAck = 1'b1;
        #1;
        chk("io_rst.ioReq", int'(bus.ioReq), 0);
        chk("io_rst.szcv", int'(bus.szcv), 0);
        chk("io_rst.ready", int'(bus.ready), 1);
        @(negedge clock);
        reset_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            if (bus.rdWrite) rdseen++;
        end
        chk("io_rst.rdWrite", rdseen, 0);
        chk("io_rst.szcv_after", int'(bus.szcv), 0);
        bus.ioAck = 1'b0;
        model_szcv = 4'b0000;

        for (int i = 0; i < 40; i++) begin
            op.instr = 16'($urandom);
            if ($urandom_range(0, 3) != 0) op.instr[15:14] = 2'b11;
            op.halt  = ($urandom_range(0, 11) == 0);
            op.sw    = 1'($urandom_range(0, 1));
            op.rw    = 1'($urandom_range(0, 1));
            op.flags = 4'($urandom_range(0, 15));
            op.w     = $urandom_range(0, 4);
            e = model(op, model_szcv);
            run_op(op, r, stab);
            compare($sformatf("rnd%0d", i), r, e, stab);
            model_szcv = e.szcv;
            if (e.halted_at != 0) do_reset($sformatf("rnd_rst%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end
endmodule
